// File: rtl/md_particle_packer_if.sv
// Record input stream and packed AXI-Stream output of the particle packer.
// master is the packer side; slave is the record source / stream sink side.
interface md_particle_packer_if #(
  parameter int AXIS_TDATA_WIDTH      = 512,
  parameter int REC_WIDTH             = 192,
  parameter int STREAMING_TDEST_WIDTH = 16
);
  logic [REC_WIDTH-1:0]             rec_data;
  logic                             rec_valid;
  logic                             rec_ready;
  logic [AXIS_TDATA_WIDTH-1:0]      M_AXIS_k2h_tdata;
  logic [AXIS_TDATA_WIDTH/8-1:0]    M_AXIS_k2h_tkeep;
  logic                             M_AXIS_k2h_tvalid;
  logic                             M_AXIS_k2h_tlast;
  logic [STREAMING_TDEST_WIDTH-1:0] M_AXIS_k2h_tdest;
  logic                             M_AXIS_k2h_tready;

  modport master (
    input  rec_data, rec_valid, M_AXIS_k2h_tready,
    output rec_ready, M_AXIS_k2h_tdata, M_AXIS_k2h_tkeep, M_AXIS_k2h_tvalid,
           M_AXIS_k2h_tlast, M_AXIS_k2h_tdest
  );

  modport slave (
    output rec_data, rec_valid, M_AXIS_k2h_tready,
    input  rec_ready, M_AXIS_k2h_tdata, M_AXIS_k2h_tkeep, M_AXIS_k2h_tvalid,
           M_AXIS_k2h_tlast, M_AXIS_k2h_tdest
  );
endinterface

// File: rtl/md_particle_packer.sv
// Packs floor(AXIS/REC) particle records per output beat; a completed beat reaches tvalid the next cycle.
// Records stall only while a finished beat waits behind an output register that is held by the sink.
module md_particle_packer #(
  parameter int AXIS_TDATA_WIDTH      = 512,
  parameter int REC_WIDTH             = 192,
  parameter int STREAMING_TDEST_WIDTH = 16,
  parameter int CNT_WIDTH             = 16
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_records,
  input  logic [STREAMING_TDEST_WIDTH-1:0] dest_id,
  md_particle_packer_if.master             bus,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_WIDTH-1:0]             records_sent,
  output logic [CNT_WIDTH-1:0]             beats_sent
);

  localparam int L         = AXIS_TDATA_WIDTH / REC_WIDTH;
  localparam int KEEP_W    = AXIS_TDATA_WIDTH / 8;
  localparam int REC_BYTES = REC_WIDTH / 8;
  localparam int LW        = $clog2(L + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PACK  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                       state;
  logic [CNT_WIDTH-1:0]             num_lat;
  logic [STREAMING_TDEST_WIDTH-1:0] dest_lat;

  logic [AXIS_TDATA_WIDTH-1:0] asm_dat;
  logic [LW-1:0]               asm_cnt;
  logic                        asm_full;
  logic                        asm_last;

  logic [AXIS_TDATA_WIDTH-1:0] out_dat;
  logic [KEEP_W-1:0]           out_keep;
  logic                        out_vld;
  logic                        out_last;

  logic                        rec_rdy;
  logic                        rec_hs;
  logic                        out_hs;
  logic                        out_free;
  logic                        last_rec;
  logic                        beat_done;
  logic [LW-1:0]               cnt_inc;
  logic [AXIS_TDATA_WIDTH-1:0] merged;

  function automatic logic [KEEP_W-1:0] keep_for(input logic [LW-1:0] n);
    logic [KEEP_W-1:0] kp;
    kp = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      kp[b] = (b < int'(n) * REC_BYTES);
    end
    return kp;
  endfunction

  assign rec_rdy   = (state == PACK) && !asm_full;
  assign rec_hs    = bus.rec_valid && rec_rdy;
  assign out_hs    = out_vld && bus.M_AXIS_k2h_tready;
  assign out_free  = !out_vld || bus.M_AXIS_k2h_tready;
  assign last_rec  = (records_sent + CNT_WIDTH'(1)) == num_lat;
  assign cnt_inc   = asm_cnt + LW'(1);
  assign beat_done = rec_hs && ((asm_cnt == LW'(L - 1)) || last_rec);

  // Current lanes plus the incoming record dropped into the next free lane.
  always_comb begin
    merged = asm_dat;
    for (int k = 0; k < L; k++) begin
      if (LW'(k) == asm_cnt) begin
        merged[k*REC_WIDTH +: REC_WIDTH] = bus.rec_data;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      num_lat  <= '0;
      dest_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_lat  <= num_records;
            dest_lat <= dest_id;
            state    <= (num_records == '0) ? DONE : PACK;
          end
        end
        PACK: begin
          if (rec_hs && last_rec) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_hs && out_last) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      records_sent <= '0;
      beats_sent   <= '0;
    end else if (state == IDLE && start) begin
      records_sent <= '0;
      beats_sent   <= '0;
    end else begin
      if (rec_hs) begin
        records_sent <= records_sent + CNT_WIDTH'(1);
      end
      if (out_hs) begin
        beats_sent <= beats_sent + CNT_WIDTH'(1);
      end
    end
  end

  // Assembly lanes: a completed beat skips straight to the output register when it is free,
  // otherwise it parks here and rec_ready drops until the sink drains.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      asm_dat  <= '0;
      asm_cnt  <= '0;
      asm_full <= 1'b0;
      asm_last <= 1'b0;
    end else if (beat_done) begin
      if (out_free) begin
        asm_dat  <= '0;
        asm_cnt  <= '0;
        asm_full <= 1'b0;
        asm_last <= 1'b0;
      end else begin
        asm_dat  <= merged;
        asm_cnt  <= cnt_inc;
        asm_full <= 1'b1;
        asm_last <= last_rec;
      end
    end else if (rec_hs) begin
      asm_dat <= merged;
      asm_cnt <= cnt_inc;
    end else if (asm_full && out_free) begin
      asm_dat  <= '0;
      asm_cnt  <= '0;
      asm_full <= 1'b0;
      asm_last <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else if (beat_done && out_free) begin
      out_vld  <= 1'b1;
      out_dat  <= merged;
      out_keep <= keep_for(cnt_inc);
      out_last <= last_rec;
    end else if (asm_full && out_free) begin
      out_vld  <= 1'b1;
      out_dat  <= asm_dat;
      out_keep <= keep_for(asm_cnt);
      out_last <= asm_last;
    end else if (out_hs) begin
      out_vld <= 1'b0;
    end
  end

  assign bus.rec_ready         = rec_rdy;
  assign bus.M_AXIS_k2h_tdata  = out_dat;
  assign bus.M_AXIS_k2h_tkeep  = out_keep;
  assign bus.M_AXIS_k2h_tvalid = out_vld;
  assign bus.M_AXIS_k2h_tlast  = out_last;
  assign bus.M_AXIS_k2h_tdest  = dest_lat;

  assign busy = (state == PACK) || (state == FLUSH);
  assign done = (state == DONE);

endmodule

// File: tb/tb_md_particle_packer.sv
// Bench for md_particle_packer: table of jobs with randomized valid/ready, checked against a lane-packing model.
module tb_md_particle_packer;
  localparam int AW = 512;
  localparam int RW = 192;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int L  = AW / RW;
  localparam logic [63:0] K1 = 64'h0000_0000_00FF_FFFF;
  localparam logic [63:0] K2 = 64'h0000_FFFF_FFFF_FFFF;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_records = '0;
  logic [DW-1:0] dest_id = '0;
  logic          busy, done;
  logic [CW-1:0] records_sent, beats_sent;

  md_particle_packer_if #(.AXIS_TDATA_WIDTH(AW), .REC_WIDTH(RW), .STREAMING_TDEST_WIDTH(DW)) bus ();

  md_particle_packer #(
    .AXIS_TDATA_WIDTH(AW), .REC_WIDTH(RW), .STREAMING_TDEST_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .num_records(num_records),
    .dest_id(dest_id), .bus(bus), .busy(busy), .done(done),
    .records_sent(records_sent), .beats_sent(beats_sent)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          num;
    logic [15:0] dest;
    int          vld_pct;
    int          rdy_pct;
    int          exp_beats;
    logic [63:0] exp_last_keep;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int failures = 0;
  logic [RW-1:0] recs[$];
  int cur_num;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_rec();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Beat b carries records b*L .. b*L+L-1 (those that exist), lane k at bit k*RW.
  function automatic logic [AW-1:0] exp_data(input int b);
    logic [AW-1:0] d;
    d = '0;
    for (int k = 0; k < L; k++) begin
      if (b * L + k < cur_num) d[k*RW +: RW] = recs[b*L + k];
    end
    return d;
  endfunction

  function automatic logic [63:0] exp_keep(input int b);
    logic [63:0] kp;
    int n;
    n = cur_num - b * L;
    if (n > L) n = L;
    kp = '0;
    for (int i = 0; i < 64; i++) kp[i] = (i < n * (RW / 8));
    return kp;
  endfunction

  task automatic run_job(input int num, input logic [15:0] dest, input int vp, input int rp,
                         input int ebeats, input logic [63:0] ekeep,
                         input bit mid_start, input bit stall5);
    int idx, bidx, last_beat, want_cyc;
    bit got_done, prev_stall;
    logic [AW-1:0] pd;
    logic [63:0] pk, last_keep;
    logic pl;
    logic [15:0] pdst;
    recs.delete();
    cur_num = num;
    for (int i = 0; i < num; i++) recs.push_back(rand_rec());
    last_beat = (num + L - 1) / L - 1;
    start = 1'b1;
    num_records = CW'(num);
    dest_id = dest;
    idx = 0; bidx = 0; got_done = 0; prev_stall = 0;
    pd = '0; pk = '0; pl = 1'b0; pdst = '0; last_keep = '0;
    for (int j = 0; j < 3000 && !got_done; j++) begin
      @(negedge ap_clk);
      start = mid_start && (j == 3);
      if (mid_start) begin
        dest_id = 16'($urandom);
        num_records = 16'd1;
      end
      bus.rec_valid = (idx < num) && ($urandom_range(99) < vp);
      bus.rec_data = bus.rec_valid ? recs[idx] : rand_rec();
      bus.M_AXIS_k2h_tready = ($urandom_range(99) < rp) && !(stall5 && j >= 2 && j <= 6);
      #1;
      if (j == 0) chk("busy_in_job", busy, 1'b1);
      if (stall5 && j == 5) chk("rec_ready_backpressure", bus.rec_ready, 1'b0);
      if (prev_stall) begin
        chk("hold_tvalid", bus.M_AXIS_k2h_tvalid, 1'b1);
        chk("hold_tdata", bus.M_AXIS_k2h_tdata, pd);
        chk("hold_tkeep", bus.M_AXIS_k2h_tkeep, pk);
        chk("hold_tlast", bus.M_AXIS_k2h_tlast, pl);
        chk("hold_tdest", bus.M_AXIS_k2h_tdest, pdst);
      end
      if (bus.rec_valid && bus.rec_ready) idx++;
      if (bus.M_AXIS_k2h_tvalid && bus.M_AXIS_k2h_tready) begin
        chk("beat_tdata", bus.M_AXIS_k2h_tdata, exp_data(bidx));
        chk("beat_tkeep", bus.M_AXIS_k2h_tkeep, exp_keep(bidx));
        chk("beat_tlast", bus.M_AXIS_k2h_tlast, (bidx == last_beat));
        chk("beat_tdest", bus.M_AXIS_k2h_tdest, dest);
        if (vp == 100 && rp == 100 && !stall5) begin
          want_cyc = ((bidx + 1) * L < num) ? (bidx + 1) * L : num;
          chk("beat_cycle", j, want_cyc);
        end
        last_keep = bus.M_AXIS_k2h_tkeep;
        bidx++;
      end
      prev_stall = bus.M_AXIS_k2h_tvalid && !bus.M_AXIS_k2h_tready;
      pd = bus.M_AXIS_k2h_tdata;
      pk = bus.M_AXIS_k2h_tkeep;
      pl = bus.M_AXIS_k2h_tlast;
      pdst = bus.M_AXIS_k2h_tdest;
      if (done) begin
        got_done = 1;
        chk("busy_low_at_done", busy, 1'b0);
      end
    end
    chk("done_seen", got_done, 1'b1);
    chk("records_sent", records_sent, CW'(num));
    chk("beats_sent", beats_sent, CW'(ebeats));
    chk("beats_seen", bidx, ebeats);
    chk("records_consumed", idx, num);
    chk("last_tkeep", last_keep, ekeep);
    @(negedge ap_clk);
    start = 1'b0;
    bus.rec_valid = 1'b0;
    bus.M_AXIS_k2h_tready = 1'b1;
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_tvalid", bus.M_AXIS_k2h_tvalid, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, bus.M_AXIS_k2h_tvalid, 1'b0);
    chk({tag, "_tlast"}, bus.M_AXIS_k2h_tlast, 1'b0);
    chk({tag, "_tdata"}, bus.M_AXIS_k2h_tdata, '0);
    chk({tag, "_tkeep"}, bus.M_AXIS_k2h_tkeep, '0);
    chk({tag, "_tdest"}, bus.M_AXIS_k2h_tdest, '0);
    chk({tag, "_rec_ready"}, bus.rec_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_records_sent"}, records_sent, '0);
    chk({tag, "_beats_sent"}, beats_sent, '0);
  endtask

  initial begin
    vecs[0] = '{4,  16'h0011, 100, 100, 2,  K2};
    vecs[1] = '{3,  16'h0022, 100, 100, 2,  K1};
    vecs[2] = '{1,  16'h0033, 100, 100, 1,  K1};
    vecs[3] = '{7,  16'h0044, 60,  50,  4,  K1};
    vecs[4] = '{8,  16'h0055, 70,  40,  4,  K2};
    vecs[5] = '{5,  16'h0066, 100, 30,  3,  K1};
    vecs[6] = '{20, 16'h0077, 50,  50,  10, K2};

    bus.rec_valid = 1'b0;
    bus.rec_data = '0;
    bus.M_AXIS_k2h_tready = 1'b1;
    #2;
    chk_reset_outputs("reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_job(vecs[i].num, vecs[i].dest, vecs[i].vld_pct, vecs[i].rdy_pct,
              vecs[i].exp_beats, vecs[i].exp_last_keep, 1'b0, 1'b0);
    end

    // Zero-length job, with a start in the DONE cycle that must be ignored.
    @(negedge ap_clk);
    start = 1'b1;
    num_records = '0;
    dest_id = 16'h0BAD;
    @(negedge ap_clk);
    num_records = 16'd2;
    #1;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_tvalid", bus.M_AXIS_k2h_tvalid, 1'b0);
    @(negedge ap_clk);
    start = 1'b0;
    #1;
    chk("zero_done_pulse", done, 1'b0);
    chk("start_in_done_ignored", busy, 1'b0);
    chk("zero_tvalid_after", bus.M_AXIS_k2h_tvalid, 1'b0);

    run_job(6, 16'h0ABC, 100, 100, 3, K2, 1'b0, 1'b1);
    run_job(8, 16'h7777, 100, 100, 4, K2, 1'b1, 1'b0);

    // Reset after one accepted record, then a fresh two-record job right after release.
    start = 1'b1;
    num_records = 16'd4;
    dest_id = 16'h1234;
    @(negedge ap_clk);
    start = 1'b0;
    bus.rec_valid = 1'b1;
    bus.rec_data = rand_rec();
    @(negedge ap_clk);
    bus.rec_valid = 1'b0;
    #1;
    chk("pre_reset_records", records_sent, 16'd1);
    chk("pre_reset_tdest", bus.M_AXIS_k2h_tdest, 16'h1234);
    ap_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midjob_reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run_job(2, 16'h00A5, 100, 100, 1, K2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
